ro_scan_ctrl: RTL

- Measurement scheduler for the ring-oscillator counting datapath.
- Time-shares a single Counting_circuit instance among NUM_RO ring oscillators. Only one oscillator is enabled at a time.
- For each oscillator, in order, it clears the counter, opens a fixed counting window, then captures the 8-bit count.
- Results are tagged with the oscillator index. Supports one-shot sweeps and continuous sweeps.

---
 rtl/ro_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ro_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ro_scan_ctrl
//  Purpose  : Measurement scheduler that time-shares one counting circuit
//             among NUM_RO ring oscillators. For each oscillator in turn it
//             holds the counter clear while the oscillator settles, opens a
//             fixed counting window, waits for the count to become stable,
//             then captures the 8-bit count tagged with the oscillator index.
//             Supports one-shot and continuous sweeps, and abort.
//  Options  : RO_PUF_BIT_EN - adds puf_bit/puf_valid outputs that compare
//             each even/odd oscillator pair (count(k-1) > count(k)).
//  Revision : 1.0 - initial release
// ============================================================================
module ro_scan_ctrl #(
  parameter int NUM_RO  = 4,
  parameter int IDX_W   = 2,
  parameter int SETTLE  = 8,
  parameter int WINDOW  = 64,
  parameter int CNT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont_mode,
  input  logic              abort,
  input  logic [7:0]        count_in,
  output logic [NUM_RO-1:0] ro_en,
  output logic [IDX_W-1:0]  ro_sel,
  output logic              cnt_clr,
  output logic              cnt_gate,
  output logic [7:0]        result,
  output logic [IDX_W-1:0]  result_id,
  output logic              result_valid,
  output logic              sweep_done,
  output logic              busy
`ifdef RO_PUF_BIT_EN
  ,
  output logic              puf_bit,
  output logic              puf_valid
`endif
);

  // Phase counter must hold the longest of the three timed phases minus one.
  localparam int C_MAX_A   = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int C_MAX_P   = (C_MAX_A > CNT_LAT) ? C_MAX_A : CNT_LAT;
  localparam int C_CNT_W   = $clog2(C_MAX_P + 1);

  localparam logic [C_CNT_W-1:0] C_SETTLE_LAST = C_CNT_W'(SETTLE - 1);
  localparam logic [C_CNT_W-1:0] C_WINDOW_LAST = C_CNT_W'(WINDOW - 1);
  localparam logic [C_CNT_W-1:0] C_LAT_LAST    = C_CNT_W'(CNT_LAT - 1);
  localparam logic [IDX_W-1:0]   C_IDX_LAST    = IDX_W'(NUM_RO - 1);

  localparam logic [2:0] C_ST_IDLE    = 3'd0;
  localparam logic [2:0] C_ST_SETTLE  = 3'd1;
  localparam logic [2:0] C_ST_COUNT   = 3'd2;
  localparam logic [2:0] C_ST_WAIT    = 3'd3;
  localparam logic [2:0] C_ST_CAPTURE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [C_CNT_W-1:0] phase_q, phase_d;
  logic [7:0]         result_q, result_d;
  logic [IDX_W-1:0]   result_id_q, result_id_d;
  logic               result_valid_q, result_valid_d;
  logic               sweep_done_q, sweep_done_d;
  logic [NUM_RO-1:0]  ro_en_q, ro_en_d;
  logic               cnt_clr_q, cnt_clr_d;
  logic               cnt_gate_q, cnt_gate_d;
  logic               busy_q, busy_d;

  // Sequencer: next state, oscillator index, phase counter and capture.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    phase_d        = phase_q;
    result_d       = result_q;
    result_id_d    = result_id_q;
    result_valid_d = 1'b0;
    sweep_done_d   = 1'b0;
    if (abort) begin
      // Abort wins over everything and drops any in-flight measurement.
      state_d = C_ST_IDLE;
      idx_d   = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        C_ST_IDLE: begin
          if (start) begin
            state_d = C_ST_SETTLE;
            idx_d   = '0;
            phase_d = '0;
          end
        end
        C_ST_SETTLE: begin
          if (phase_q == C_SETTLE_LAST) begin
            state_d = C_ST_COUNT;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        C_ST_COUNT: begin
          if (phase_q == C_WINDOW_LAST) begin
            state_d = (CNT_LAT == 0) ? C_ST_CAPTURE : C_ST_WAIT;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        C_ST_WAIT: begin
          if (phase_q == C_LAT_LAST) begin
            state_d = C_ST_CAPTURE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        C_ST_CAPTURE: begin
          result_d       = count_in;
          result_id_d    = idx_q;
          result_valid_d = 1'b1;
          phase_d        = '0;
          if (idx_q == C_IDX_LAST) begin
            sweep_done_d = 1'b1;
            idx_d        = '0;
            state_d      = cont_mode ? C_ST_SETTLE : C_ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = C_ST_SETTLE;
          end
        end
        default: begin
          state_d = C_ST_IDLE;
          idx_d   = '0;
          phase_d = '0;
        end
      endcase
    end
  end

  // Counter-facing outputs follow the next state so they line up with it.
  always_comb begin
    busy_d     = (state_d != C_ST_IDLE);
    cnt_clr_d  = (state_d == C_ST_SETTLE);
    cnt_gate_d = (state_d == C_ST_COUNT);
    ro_en_d    = '0;
    for (int i = 0; i < NUM_RO; i++) begin
      ro_en_d[i] = busy_d && (idx_d == IDX_W'(i));
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= C_ST_IDLE;
      idx_q          <= '0;
      phase_q        <= '0;
      result_q       <= '0;
      result_id_q    <= '0;
      result_valid_q <= 1'b0;
      sweep_done_q   <= 1'b0;
      ro_en_q        <= '0;
      cnt_clr_q      <= 1'b0;
      cnt_gate_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      phase_q        <= phase_d;
      result_q       <= result_d;
      result_id_q    <= result_id_d;
      result_valid_q <= result_valid_d;
      sweep_done_q   <= sweep_done_d;
      ro_en_q        <= ro_en_d;
      cnt_clr_q      <= cnt_clr_d;
      cnt_gate_q     <= cnt_gate_d;
      busy_q         <= busy_d;
    end
  end

  assign ro_en        = ro_en_q;
  assign ro_sel       = idx_q;
  assign cnt_clr      = cnt_clr_q;
  assign cnt_gate     = cnt_gate_q;
  assign result       = result_q;
  assign result_id    = result_id_q;
  assign result_valid = result_valid_q;
  assign sweep_done   = sweep_done_q;
  assign busy         = busy_q;

`ifdef RO_PUF_BIT_EN
  logic [7:0] even_cnt_q, even_cnt_d;
  logic       even_vld_q, even_vld_d;
  logic       puf_bit_q, puf_bit_d;
  logic       puf_valid_q, puf_valid_d;

  // Pair comparison: keep the even-index count, compare on the odd capture.
  always_comb begin
    even_cnt_d  = even_cnt_q;
    even_vld_d  = even_vld_q;
    puf_bit_d   = puf_bit_q;
    puf_valid_d = 1'b0;
    if (abort) begin
      even_cnt_d = '0;
      even_vld_d = 1'b0;
    end else if (state_q == C_ST_CAPTURE) begin
      if (!idx_q[0]) begin
        even_cnt_d = count_in;
        even_vld_d = 1'b1;
      end else if (even_vld_q) begin
        puf_bit_d   = (even_cnt_q > count_in);
        puf_valid_d = 1'b1;
        even_vld_d  = 1'b0;
      end
    end
  end

  // Pair-comparison registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      even_cnt_q  <= '0;
      even_vld_q  <= 1'b0;
      puf_bit_q   <= 1'b0;
      puf_valid_q <= 1'b0;
    end else begin
      even_cnt_q  <= even_cnt_d;
      even_vld_q  <= even_vld_d;
      puf_bit_q   <= puf_bit_d;
      puf_valid_q <= puf_valid_d;
    end
  end

  assign puf_bit   = puf_bit_q;
  assign puf_valid = puf_valid_q;
`else
  // Pair comparison not built: no extra state or outputs.
`endif

endmodule
`default_nettype wire
